// File: rtl/intc_err_req.sv
// Error interrupt requester: edge-detects error sources, keeps pending flags and hands the
// lowest-index active source to the CPU. Define INTC_ERR_SYNC_EN to add 2-flop input syncs.
module intc_err_req #(
    parameter int unsigned NERR    = 8,
    parameter int unsigned VW      = $clog2(NERR),
    parameter logic [3:0]  ERR_LVL = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NERR-1:0] err_i,
    input  logic [NERR-1:0] err_msk_i,
    input  logic [NERR-1:0] clr_rg_i,
    input  logic            cpu_ack_i,
    output logic [NERR-1:0] err_pend_o,
    output logic            err_req_o,
    output logic [3:0]      err_lvl_o,
    output logic [VW-1:0]   err_vec_o,
    output logic            sync_cpu_int_o
);

    typedef enum logic [1:0] {StIdle, StReq, StAckd, StDone} state_e;

    state_e          state_q, state_d;
    logic [NERR-1:0] s;
    logic [NERR-1:0] s_d_q;
    logic [NERR-1:0] evt;
    logic [NERR-1:0] act;
    logic [NERR-1:0] pend_q, pend_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [VW-1:0]   win;
    logic            req_q;
    logic [3:0]      lvl_q;
    logic            sync_q;
    logic [1:0]      arm_cnt_q;
    logic            armed;

`ifdef INTC_ERR_SYNC_EN
    localparam int unsigned ArmLen = 3;

    logic [NERR-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= err_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    localparam int unsigned ArmLen = 1;

    assign s = err_i;
`endif

    // Edges are ignored until the input pipeline has refilled after reset, so a
    // source already high at release is not mistaken for a fresh event.
    assign armed = (arm_cnt_q == 2'(ArmLen));

    assign evt    = s & ~s_d_q & {NERR{armed}};
    assign act    = pend_q & err_msk_i;
    assign pend_d = (pend_q & ~clr_rg_i) | (evt & err_msk_i);

    always_comb begin
        win = '0;
        for (int i = NERR - 1; i >= 0; i--) begin
            if (act[i]) begin
                win = VW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                if (|act) begin
                    state_d = StReq;
                    vec_d   = win;
                end
            end
            StReq: begin
                if (cpu_ack_i) begin
                    state_d = StAckd;
                end else if (!act[vec_q]) begin
                    state_d = StIdle;
                end
            end
            StAckd: begin
                if (!pend_q[vec_q]) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            s_d_q     <= '0;
            pend_q    <= '0;
            vec_q     <= '0;
            req_q     <= 1'b0;
            lvl_q     <= '0;
            sync_q    <= 1'b0;
            arm_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            s_d_q   <= s;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            req_q   <= (state_d == StReq);
            lvl_q   <= (state_d == StReq) ? ERR_LVL : 4'h0;
            sync_q  <= (state_d == StDone);
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    assign err_pend_o     = pend_q;
    assign err_req_o      = req_q;
    assign err_lvl_o      = lvl_q;
    assign err_vec_o      = vec_q;
    assign sync_cpu_int_o = sync_q;

endmodule

// File: doc/intc_err_req.md
INTC_ERR_REQ -- requirements
Module: intc_err_req

Interface
REQ-001 Parameter NERR, default 8, number of error request sources (2..32).
REQ-002 Parameter VW, default $clog2(NERR), width of err_vec_o.
REQ-003 Parameter ERR_LVL, default 4'hF, interrupt level presented with every error request.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 err_i  input  NERR  raw error event lines, level, rising edge = event.
REQ-007 err_msk_i  input  NERR  enable mask, 1 = source enabled.
REQ-008 clr_rg_i  input  NERR  clear vector driven by the error clear register.
REQ-009 cpu_ack_i  input  1  CPU acceptance of the error interrupt, single-cycle pulse.
REQ-010 err_pend_o  output  NERR  pending flags, registered.
REQ-011 err_req_o  output  1  interrupt request to CPU, registered.
REQ-012 err_lvl_o  output  4  equals ERR_LVL while err_req_o=1, else 0.
REQ-013 err_vec_o  output  VW  index of the source being requested, frozen while err_req_o=1.
REQ-014 sync_cpu_int_o  output  1  one-cycle pulse telling the clear register its clear has been consumed.

Function
REQ-015 Event: evt[n] = s[n] & ~s_d[n]; s is the conditioned err_i, s_d is s delayed one cycle.
REQ-016 Pending update: pend_nxt = (pend & ~clr_rg_i) | (evt & err_msk_i); set wins over clear on the same bit in the same cycle.
REQ-017 Masked events are discarded, not remembered; masking an already pending bit does not clear it but removes it from arbitration (act = pend & err_msk_i).
REQ-018 Arbitration: fixed priority, lowest index wins among act bits.
REQ-019 FSM states IDLE, REQ, ACKD, DONE; one-hot or binary encoding is free.
REQ-020 IDLE: if |act, go to REQ, latch winning index into err_vec_o; err_req_o=1 from the next cycle.
REQ-021 REQ: err_req_o=1, err_vec_o held; cpu_ack_i=1 -> ACKD; else if act[err_vec_o]=0 (cleared or masked) -> IDLE, request withdrawn; ack takes priority if both occur in the same cycle.
REQ-022 ACKD: err_req_o=0; wait until pend[err_vec_o]=0, then go to DONE.
REQ-023 DONE: sync_cpu_int_o=1 for exactly one cycle, then go to IDLE; new arbitration is possible on the following cycle.
REQ-024 cpu_ack_i outside REQ is ignored.
REQ-025 An event on the requested source while in ACKD re-sets pend, which keeps the FSM in ACKD until the bit is cleared again.
REQ-026 Latency with synchronizer: err_i high at sample edge k -> err_pend_o bit high after edge k+3, err_req_o high after edge k+4.
REQ-027 Latency without synchronizer: err_pend_o after edge k+1, err_req_o after edge k+2.

Reset
REQ-028 rst_n low clears asynchronously: synchronizer and delay flops, pend, FSM (IDLE), err_req_o, err_vec_o, err_lvl_o, sync_cpu_int_o, all to 0.
REQ-029 Reset deassertion mid-operation restarts from IDLE; an err_i already high at release produces no event.

Configuration
REQ-030 Macro INTC_ERR_SYNC_EN defined: err_i passes through a two-flop synchronizer per bit before edge detection (asynchronous sources allowed).
REQ-031 Macro INTC_ERR_SYNC_EN undefined: s = err_i directly; err_i must be synchronous to clk.

Verification
REQ-032 Sync on, msk=8'hFF, err_i[3] rises -> err_pend_o=8'h08 after 3 edges, err_req_o=1, err_vec_o=3, err_lvl_o=4'hF after 4 edges.
REQ-033 err_i[5] and err_i[2] rise together -> err_vec_o=2; ack, clr_rg_i=8'h04 -> sync_cpu_int_o single pulse, then request with err_vec_o=5.
REQ-034 Request on bit 1, clr_rg_i=8'h02 before ack -> err_req_o drops, FSM returns to IDLE, no sync_cpu_int_o pulse.
REQ-035 Event and clr_rg_i on bit 0 in the same cycle -> err_pend_o[0] stays 1.
REQ-036 err_msk_i=8'hFE, err_i[0] pulses -> err_pend_o stays 0, err_req_o stays 0.
REQ-037 rst_n low during ACKD -> all outputs 0 immediately, without waiting for a clk edge; a source still high at release causes no request.
